// File: rtl/ulpb_layer_pwr_seq_if.sv
// ulpb_layer_pwr_seq_if: request and per-domain control bundle
// master drives WAKE_REQ/SLEEP_REQ; slave (the sequencer) drives the rest.
interface ulpb_layer_pwr_seq_if #(
    parameter int NUM_DOMAINS = 2,
    parameter int IDX_WIDTH   = 3
);
    logic [NUM_DOMAINS-1:0] WAKE_REQ;
    logic [NUM_DOMAINS-1:0] SLEEP_REQ;
    logic [NUM_DOMAINS-1:0] POWER_ON;
    logic [NUM_DOMAINS-1:0] RELEASE_CLK;
    logic [NUM_DOMAINS-1:0] RELEASE_RST;
    logic [NUM_DOMAINS-1:0] RELEASE_ISO;
    logic [NUM_DOMAINS-1:0] ACTIVE;
    logic                   BUSY;
    logic [IDX_WIDTH-1:0]   CUR_DOMAIN;

    modport master (
        output WAKE_REQ, SLEEP_REQ,
        input  POWER_ON, RELEASE_CLK, RELEASE_RST,
        input  RELEASE_ISO, ACTIVE, BUSY, CUR_DOMAIN
    );

    modport slave (
        input  WAKE_REQ, SLEEP_REQ,
        output POWER_ON, RELEASE_CLK, RELEASE_RST,
        output RELEASE_ISO, ACTIVE, BUSY, CUR_DOMAIN
    );
endinterface

// File: rtl/ulpb_layer_pwr_seq.sv
// ulpb_layer_pwr_seq: always-on sequencer, one domain in transition at a time.
// Ports: CLKIN, RESETn (async low), bus (slave: requests in, holds/status out).
module ulpb_layer_pwr_seq #(
    parameter int NUM_DOMAINS = 2,
    parameter int STEP_CYCLES = 4,
    parameter int CNT_WIDTH   = 4,
    parameter int IDX_WIDTH   = 3
) (
    input logic                  CLKIN,
    input logic                  RESETn,
    ulpb_layer_pwr_seq_if.slave  bus
);
    localparam int N = NUM_DOMAINS;

    typedef enum logic [2:0] {
        IDLE, W_PWR, W_CLK, W_RST, S_ISO, S_RST, S_CLK
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] tmr_q, tmr_d;
    logic [IDX_WIDTH-1:0] cur_q, cur_d, gnt_idx;
    logic                 busy_q, busy_d;
    logic [N-1:0]         pwr_q, pwr_d;
    logic [N-1:0]         clk_q, clk_d;
    logic [N-1:0]         rst_q, rst_d;
    logic [N-1:0]         iso_q, iso_d;
    logic [N-1:0]         act_q, act_d;
    logic [N-1:0]         pend, gnt, sel;
    logic                 tc;

    // ACTIVE doubles as the stored steady state of each domain.
    assign pend = (~act_q & bus.WAKE_REQ) | (act_q & bus.SLEEP_REQ);
    assign sel  = N'(1) << cur_q;
    assign tc   = (tmr_q == CNT_WIDTH'(STEP_CYCLES - 1));

    // Lowest pending index wins: scan high to low, last hit sticks.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cur_d   = cur_q;
        busy_d  = busy_q;
        pwr_d   = pwr_q;
        clk_d   = clk_q;
        rst_d   = rst_q;
        iso_d   = iso_q;
        act_d   = act_q;
        unique case (state_q)
            IDLE: begin
                if (|pend) begin
                    cur_d  = gnt_idx;
                    busy_d = 1'b1;
                    if (|(act_q & gnt)) begin
                        state_d = S_ISO;
                        iso_d   = iso_q | gnt;
                        act_d   = act_q & ~gnt;
                    end else begin
                        state_d = W_PWR;
                        pwr_d   = pwr_q & ~gnt;
                    end
                end
            end
            W_PWR: if (tc) begin
                state_d = W_CLK;
                clk_d   = clk_q & ~sel;
            end
            W_CLK: if (tc) begin
                state_d = W_RST;
                rst_d   = rst_q & ~sel;
            end
            W_RST: if (tc) begin
                state_d = IDLE;
                iso_d   = iso_q & ~sel;
                act_d   = act_q | sel;
                busy_d  = 1'b0;
                cur_d   = '0;
            end
            S_ISO: if (tc) begin
                state_d = S_RST;
                rst_d   = rst_q | sel;
            end
            S_RST: if (tc) begin
                state_d = S_CLK;
                clk_d   = clk_q | sel;
            end
            S_CLK: if (tc) begin
                state_d = IDLE;
                pwr_d   = pwr_q | sel;
                busy_d  = 1'b0;
                cur_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        // Timer restarts on every state change, runs only mid-sequence.
        if (state_d != state_q)
            tmr_d = '0;
        else if (state_q != IDLE)
            tmr_d = tmr_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cur_q   <= '0;
            busy_q  <= 1'b0;
            pwr_q   <= '1;
            clk_q   <= '1;
            rst_q   <= '1;
            iso_q   <= '1;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cur_q   <= cur_d;
            busy_q  <= busy_d;
            pwr_q   <= pwr_d;
            clk_q   <= clk_d;
            rst_q   <= rst_d;
            iso_q   <= iso_d;
            act_q   <= act_d;
        end
    end

    assign bus.POWER_ON    = pwr_q;
    assign bus.RELEASE_CLK = clk_q;
    assign bus.RELEASE_RST = rst_q;
    assign bus.RELEASE_ISO = iso_q;
    assign bus.ACTIVE      = act_q;
    assign bus.BUSY        = busy_q;
    assign bus.CUR_DOMAIN  = cur_q;
endmodule
